// File: rtl/mem_port_responder_if.sv
// Request/response bundle between the CPU memory port (master) and the memory responder (slave).
// req_be only exists when MEM_PORT_BYTE_EN is defined.
interface mem_port_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
`ifdef MEM_PORT_BYTE_EN
  logic [3:0]  req_be;
`endif
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
`ifdef MEM_PORT_BYTE_EN
    output req_be,
`endif
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
`ifdef MEM_PORT_BYTE_EN
    input  req_be,
`endif
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_port_responder.sv
// Memory-side responder: one request at a time, response after READ_LAT cycles, error flagging.
// Optional feature macro MEM_PORT_BYTE_EN enables per-byte write enables via req_be.
module mem_port_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int READ_LAT    = 2
) (
  input logic                  clk,
  input logic                  reset,
  mem_port_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] LOAD = 3'(READ_LAT - 1);
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_next;
  logic [2:0]      cnt, cnt_next;
  logic [31:0]     mem [DEPTH_WORDS];
  logic [31:0]     rdata_q;
  logic            err_q;
  logic            ready, rsp_pulse;
  logic            accept, req_err;
  logic [AW-1:0]   idx;

  assign accept  = bus.req_valid && (state == IDLE);
  assign req_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr >= LIMIT);
  assign idx     = bus.req_addr[AW+1:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        rdata_q <= (bus.req_wr || req_err) ? 32'h0 : mem[idx];
        err_q   <= req_err;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ready      = 1'b0;
    rsp_pulse  = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (accept) begin
          cnt_next   = LOAD;
          state_next = (LOAD == 3'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - 3'd1;
        if (cnt <= 3'd1) state_next = RESP;
      end
      RESP: begin
        rsp_pulse  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Writes commit on the accept edge; the reset gate keeps an accept from landing while held in reset.
  always_ff @(posedge clk) begin
    if (reset && accept && bus.req_wr && !req_err) begin
`ifdef MEM_PORT_BYTE_EN
      for (int i = 0; i < 4; i++) begin
        if (bus.req_be[i]) mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
      end
`else
      mem[idx] <= bus.req_wdata;
`endif
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_pulse;
  assign bus.rsp_rdata = rsp_pulse ? rdata_q : 32'h0;
  assign bus.rsp_err   = rsp_pulse && err_q;

endmodule
